bridge_core_cmd: RTL and testbench

BRIDGE_CORE_CMD -- requirements
Module: bridge_core_cmd

---
 rtl/bridge_core_cmd_pkg.sv | 31 +++
 rtl/bridge_core_cmd_if.sv | 35 +++
 rtl/bridge_cmd_timer.sv | 37 +++
 rtl/bridge_core_cmd.sv | 196 +++++++++++++++++++
 tb/tb_bridge_core_cmd.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_core_cmd_pkg.sv
// Shared types and constants for the bridge core command block.
package bridge_core_cmd_pkg;

    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned TIMER_W = 32;

    // ASCII tags carried in the upper half of the command register
    localparam logic [WORD_W-1:0] TAG_CM = 16'h434D;
    localparam logic [WORD_W-1:0] TAG_BU = 16'h4255;
    localparam logic [WORD_W-1:0] TAG_OK = 16'h4F4B;

    localparam logic [WORD_W-1:0] RESULT_TIMEOUT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_RUNNING,
        ST_DONE
    } state_e;

    // Four 32-bit words; w0 occupies [127:96]
    typedef struct packed {
        logic [DATA_W-1:0] w0;
        logic [DATA_W-1:0] w1;
        logic [DATA_W-1:0] w2;
        logic [DATA_W-1:0] w3;
    } param_t;

endpackage

// File: rtl/bridge_core_cmd_if.sv
// Host bridge bus plus core request handshake.
interface bridge_core_cmd_if;
    import bridge_core_cmd_pkg::*;

    logic [31:0]       bridge_addr;
    logic              bridge_wr;
    logic [DATA_W-1:0] bridge_wr_data;
    logic              bridge_rd;
    logic [DATA_W-1:0] bridge_rd_data;
    logic              bridge_rd_hit;

    logic              req_valid;
    logic [WORD_W-1:0] req_word;
    param_t            req_param;
    logic              req_ack;
    logic [WORD_W-1:0] req_progress;
    logic              req_done;
    logic [WORD_W-1:0] req_result;
    param_t            req_response;

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        output bridge_rd_data, bridge_rd_hit,
        input  req_valid, req_word, req_param,
        output req_ack, req_progress, req_done, req_result, req_response
    );

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        input  bridge_rd_data, bridge_rd_hit,
        output req_valid, req_word, req_param,
        input  req_ack, req_progress, req_done, req_result, req_response
    );

endinterface

// File: rtl/bridge_cmd_timer.sv
// Loadable down-counter; expire_c flags the last enabled cycle of the window.
module bridge_cmd_timer
    import bridge_core_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               en,
    output logic               expire_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Reload on accept, otherwise count down while enabled and saturate at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    assign expire_c = en && (count_q == '0);

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bridge_core_cmd.sv
// Host-visible command window: hands one core command at a time to the host
// through the bridge and returns the host's result/response to the core.
module bridge_core_cmd
    import bridge_core_cmd_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  COMMAND_OFFSET   = 27'h0001000,
    parameter logic [ADDR_W-1:0]  PARAMETER_OFFSET = 27'h0010020,
    parameter logic [ADDR_W-1:0]  RESPONSE_OFFSET  = 27'h0010030,
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES   = 32'd1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    bridge_core_cmd_if.slave bus
);

    localparam logic [ADDR_W-1:0] CMD_PAR_PTR = COMMAND_OFFSET + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] CMD_RSP_PTR = COMMAND_OFFSET + ADDR_W'(8);
    localparam logic [ADDR_W-1:0] PAR_W1      = PARAMETER_OFFSET + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PAR_W2      = PARAMETER_OFFSET + ADDR_W'(8);
    localparam logic [ADDR_W-1:0] PAR_W3      = PARAMETER_OFFSET + ADDR_W'(12);
    localparam logic [ADDR_W-1:0] RSP_W1      = RESPONSE_OFFSET + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RSP_W2      = RESPONSE_OFFSET + ADDR_W'(8);
    localparam logic [ADDR_W-1:0] RSP_W3      = RESPONSE_OFFSET + ADDR_W'(12);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMEOUT_CYCLES - TIMER_W'(1);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] word_q, word_d;
    param_t            param_q, param_d;
    logic [WORD_W-1:0] progress_q, progress_d;
    logic [WORD_W-1:0] result_q, result_d;
    param_t            resp_q, resp_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_hit_q, rd_hit_d;

    logic [ADDR_W-1:0] addr_c;
    logic [WORD_W-1:0] wr_tag_c;
    logic [WORD_W-1:0] wr_val_c;
    logic              cmd_active_c;
    logic              cmd_rd_c;
    logic              cmd_wr_c;
    logic              timer_load_c;
    logic              timer_expire_c;
    logic              addr_hi_unused;

    // Only the low address bits select registers in this block
    assign addr_c         = bus.bridge_addr[ADDR_W-1:0];
    assign addr_hi_unused = ^bus.bridge_addr[31:ADDR_W];
    assign wr_tag_c       = bus.bridge_wr_data[DATA_W-1:WORD_W];
    assign wr_val_c       = bus.bridge_wr_data[WORD_W-1:0];
    assign cmd_active_c   = (state_q == ST_PENDING) || (state_q == ST_RUNNING);
    assign cmd_rd_c       = bus.bridge_rd && (addr_c == COMMAND_OFFSET);
    assign cmd_wr_c       = bus.bridge_wr && (addr_c == COMMAND_OFFSET);

    bridge_cmd_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load_c),
        .load_value (TIMER_LOAD),
        .en         (cmd_active_c),
        .expire_c   (timer_expire_c)
    );

    // Read decode; data and hit are registered for one-cycle latency
    always_comb begin
        rd_data_d = '0;
        rd_hit_d  = 1'b0;
        if (bus.bridge_rd) begin
            rd_hit_d = 1'b1;
            if (addr_c == COMMAND_OFFSET) begin
                rd_data_d = cmd_active_c ? {TAG_CM, word_q} : '0;
            end else if (addr_c == CMD_PAR_PTR) begin
                rd_data_d = DATA_W'(PARAMETER_OFFSET);
            end else if (addr_c == CMD_RSP_PTR) begin
                rd_data_d = DATA_W'(RESPONSE_OFFSET);
            end else if (addr_c == PARAMETER_OFFSET) begin
                rd_data_d = param_q.w0;
            end else if (addr_c == PAR_W1) begin
                rd_data_d = param_q.w1;
            end else if (addr_c == PAR_W2) begin
                rd_data_d = param_q.w2;
            end else if (addr_c == PAR_W3) begin
                rd_data_d = param_q.w3;
            end else begin
                rd_hit_d = 1'b0;
            end
        end
    end

    // Command FSM next-state; timeout and accept override host response writes
    always_comb begin
        state_d      = state_q;
        ack_d        = 1'b0;
        word_d       = word_q;
        param_d      = param_q;
        progress_d   = progress_q;
        result_d     = result_q;
        resp_d       = resp_q;
        timer_load_c = 1'b0;

        if (bus.bridge_wr) begin
            if (addr_c == RESPONSE_OFFSET) begin
                resp_d.w0 = bus.bridge_wr_data;
            end else if (addr_c == RSP_W1) begin
                resp_d.w1 = bus.bridge_wr_data;
            end else if (addr_c == RSP_W2) begin
                resp_d.w2 = bus.bridge_wr_data;
            end else if (addr_c == RSP_W3) begin
                resp_d.w3 = bus.bridge_wr_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    word_d       = bus.req_word;
                    param_d      = bus.req_param;
                    ack_d        = 1'b1;
                    progress_d   = '0;
                    resp_d       = '0;
                    timer_load_c = 1'b1;
                    state_d      = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (timer_expire_c) begin
                    result_d = RESULT_TIMEOUT;
                    resp_d   = '0;
                    state_d  = ST_DONE;
                end else if (cmd_rd_c) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (cmd_wr_c && (wr_tag_c == TAG_OK)) begin
                    result_d = wr_val_c;
                    state_d  = ST_DONE;
                end else begin
                    if (cmd_wr_c && (wr_tag_c == TAG_BU)) begin
                        progress_d = wr_val_c;
                    end
                    if (timer_expire_c) begin
                        result_d = RESULT_TIMEOUT;
                        resp_d   = '0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    // All state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            word_q     <= '0;
            param_q    <= '0;
            progress_q <= '0;
            result_q   <= '0;
            resp_q     <= '0;
            rd_data_q  <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            word_q     <= word_d;
            param_q    <= param_d;
            progress_q <= progress_d;
            result_q   <= result_d;
            resp_q     <= resp_d;
            rd_data_q  <= rd_data_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign bus.bridge_rd_data = rd_data_q;
    assign bus.bridge_rd_hit  = rd_hit_q;
    assign bus.req_ack        = ack_q;
    assign bus.req_done       = done_q;
    assign bus.req_progress   = progress_q;
    assign bus.req_result     = result_q;
    assign bus.req_response   = resp_q;

endmodule

// File: tb/tb_bridge_core_cmd.sv
// Self-checking bench for bridge_core_cmd, built with a 16-cycle timeout.
module tb_bridge_core_cmd;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic [15:0]  result;
        logic [127:0] resp;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset;

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];
    int        n_checks;
    int        n_fail;

    always #5 clk = ~clk;

    bridge_core_cmd_if bus ();

    bridge_core_cmd #(
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.bridge_addr    = '0;
        bus.bridge_wr      = 1'b0;
        bus.bridge_wr_data = '0;
        bus.bridge_rd      = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_word       = '0;
        bus.req_param      = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.bridge_addr = a;
        bus.bridge_rd   = 1'b1;
        tick();
        bus.bridge_rd   = 1'b0;
        d = bus.bridge_rd_data;
        h = bus.bridge_rd_hit;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.bridge_addr    = a;
        bus.bridge_wr_data = d;
        bus.bridge_wr      = 1'b1;
        tick();
        bus.bridge_wr      = 1'b0;
    endtask

    task automatic start_cmd(input logic [15:0] w, input logic [127:0] p, output bit ok);
        bus.req_word  = w;
        bus.req_param = p;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (bus.req_ack === 1'b1) ok = 1'b1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        rd_exp_t     e;
        reset = 1'b1;
        idle_bus();
        repeat (3) tick();
        n_checks++; if (bus.bridge_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00000000", bus.bridge_rd_data); end
        n_checks++; if (bus.bridge_rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %b want 0", bus.bridge_rd_hit); end
        n_checks++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.req_ack); end
        n_checks++; if (bus.req_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.req_done); end
        n_checks++; if (bus.req_progress !== 16'h0) begin n_fail++; $display("FAIL reset_progress: got %h want 0000", bus.req_progress); end
        n_checks++; if (bus.req_result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", bus.req_result); end
        n_checks++; if (bus.req_response !== 128'h0) begin n_fail++; $display("FAIL reset_response: got %h want 0", bus.req_response); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        rd_q.push_back({1'b1, 32'h0});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL reset_cmd_read: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        h;
        rd_exp_t     e;
        logic [31:0] addrs [3];
        addrs = '{32'h0000_1004, 32'h0000_1008, 32'h0000_2000};
        rd_q.push_back({1'b1, 32'h0001_0020});
        rd_q.push_back({1'b1, 32'h0001_0030});
        rd_q.push_back({1'b0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            bus_read(addrs[i], d, h);
            e = rd_q.pop_front();
            n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL decode_read[%0d]: got hit=%b data=%h want hit=%b data=%h", i, h, d, e.hit, e.data); end
        end
    endtask

    task automatic test_command();
        logic [31:0] d;
        logic        h;
        bit          ok;
        rd_exp_t     e;
        done_exp_t   de;
        logic [31:0] addrs [6];
        addrs = '{32'h0000_1000, 32'hF800_1000, 32'h0001_0020, 32'h0001_0024, 32'h0001_0028, 32'h0001_002C};
        start_cmd(16'h0042, {32'd1, 32'd2, 32'd3, 32'd4}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL cmd_ack: got 0 want 1 within 20 cycles"); end
        rd_q.push_back({1'b1, 32'h434D_0042});
        rd_q.push_back({1'b1, 32'h434D_0042});
        for (int i = 1; i <= 4; i++) rd_q.push_back({1'b1, 32'(i)});
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], d, h);
            e = rd_q.pop_front();
            n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL cmd_read[%0d]: got hit=%b data=%h want hit=%b data=%h", i, h, d, e.hit, e.data); end
            if (i == 0) begin
                n_checks++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL cmd_ack_width: got %b want 0", bus.req_ack); end
            end
        end
        for (int i = 0; i < 4; i++) bus_write(32'h0001_0030 + 32'(4 * i), 32'hA + 32'(i));
        done_q.push_back({16'h0007, 32'hA, 32'hB, 32'hC, 32'hD});
        bus_write(32'h0000_1000, 32'h4F4B_0007);
        n_checks++;
        if (bus.req_done !== 1'b1) begin
            n_fail++; $display("FAIL cmd_done: got %b want 1", bus.req_done);
        end else begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL cmd_result: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
        rd_q.push_back({1'b1, 32'h0});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL cmd_read_after_done: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
        n_checks++; if (bus.req_done !== 1'b0) begin n_fail++; $display("FAIL cmd_done_width: got %b want 0", bus.req_done); end
    endtask

    task automatic test_progress();
        logic [31:0] d;
        logic        h;
        bit          ok;
        rd_exp_t     e;
        done_exp_t   de;
        start_cmd(16'h0011, {32'd5, 32'd6, 32'd7, 32'd8}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prog_ack: got 0 want 1 within 20 cycles"); end
        bus_write(32'h0000_1000, 32'h4255_0010);
        n_checks++; if (bus.req_progress !== 16'h0) begin n_fail++; $display("FAIL prog_pending_ignored: got %h want 0000", bus.req_progress); end
        rd_q.push_back({1'b1, 32'h434D_0011});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL prog_cmd_read: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
        bus_write(32'h0000_1000, 32'h4255_0010);
        n_checks++; if (bus.req_progress !== 16'h0010) begin n_fail++; $display("FAIL prog_update: got %h want 0010", bus.req_progress); end
        n_checks++; if (bus.req_done !== 1'b0) begin n_fail++; $display("FAIL prog_no_done: got %b want 0", bus.req_done); end
        bus_write(32'h0000_1000, 32'h1234_0099);
        n_checks++; if ({bus.req_done, bus.req_progress} !== {1'b0, 16'h0010}) begin n_fail++; $display("FAIL prog_other_prefix: got done=%b prog=%h want done=0 prog=0010", bus.req_done, bus.req_progress); end
        done_q.push_back({16'h0003, 128'h0});
        bus_write(32'h0000_1000, 32'h4F4B_0003);
        n_checks++;
        if (bus.req_done !== 1'b1) begin
            n_fail++; $display("FAIL prog_done: got %b want 1", bus.req_done);
        end else begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL prog_result: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic        h;
        bit          ok;
        int          n;
        rd_exp_t     e;
        done_exp_t   de;
        start_cmd(16'h0055, {4{32'h5}}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL to_ack: got 0 want 1 within 20 cycles"); end
        n_checks++; if (bus.req_progress !== 16'h0) begin n_fail++; $display("FAIL to_progress_cleared: got %h want 0000", bus.req_progress); end
        bus_write(32'h0001_0030, 32'h0000_0055);
        done_q.push_back({16'hFFFF, 128'h0});
        n = 1;
        while (bus.req_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++; if (n != 16) begin n_fail++; $display("FAIL to_latency: got %0d cycles want 16", n); end
        if (bus.req_done === 1'b1) begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL to_result: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
        rd_q.push_back({1'b1, 32'h0});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d, bus.req_done} !== {e.hit, e.data, 1'b0}) begin n_fail++; $display("FAIL to_after: got hit=%b data=%h done=%b want hit=%b data=%h done=0", h, d, bus.req_done, e.hit, e.data); end

        // "OK" landing on the expiry cycle
        start_cmd(16'h0066, {4{32'h6}}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL race_ack: got 0 want 1 within 20 cycles"); end
        bus_read(32'h0000_1000, d, h);
        bus_write(32'h0001_0030, 32'h0000_0099);
        repeat (13) tick();
        n_checks++; if (bus.req_done !== 1'b0) begin n_fail++; $display("FAIL race_early_done: got %b want 0", bus.req_done); end
        done_q.push_back({16'h0077, 32'h99, 96'h0});
        bus_write(32'h0000_1000, 32'h4F4B_0077);
        n_checks++;
        if (bus.req_done !== 1'b1) begin
            n_fail++; $display("FAIL race_done: got %b want 1", bus.req_done);
        end else begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL race_result: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        h;
        bit          ok;
        rd_exp_t     e;
        done_exp_t   de;
        bus.req_word  = 16'h00B1;
        bus.req_param = {4{32'hB}};
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (bus.req_ack === 1'b1) ok = 1'b1;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_ack: got 0 want 1 within 20 cycles"); end
        rd_q.push_back({1'b1, 32'h434D_00B1});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL b2b_read: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
        n_checks++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_running: got %b want 0", bus.req_ack); end
        done_q.push_back({16'h00B1, 128'h0});
        bus_write(32'h0000_1000, 32'h4F4B_00B1);
        n_checks++;
        if (bus.req_done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: got %b want 1", bus.req_done);
        end else begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL b2b_result: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
        n_checks++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_done: got %b want 0", bus.req_ack); end
        tick();
        n_checks++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_idle: got %b want 0", bus.req_ack); end
        tick();
        n_checks++; if (bus.req_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack: got %b want 1", bus.req_ack); end
        bus.req_valid = 1'b0;
        bus_read(32'h0000_1000, d, h);
        done_q.push_back({16'h00B2, 128'h0});
        bus_write(32'h0000_1000, 32'h4F4B_00B2);
        n_checks++;
        if (bus.req_done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done2: got %b want 1", bus.req_done);
        end else begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL b2b_result2: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        h;
        bit          ok;
        bit          seen_done;
        rd_exp_t     e;
        done_exp_t   de;
        start_cmd(16'h00C1, {4{32'hC}}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_ack: got 0 want 1 within 20 cycles"); end
        rd_q.push_back({1'b1, 32'h434D_00C1});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL rst_read_running: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (bus.bridge_rd_hit !== 1'b0) begin n_fail++; $display("FAIL rst_async_hit: got %b want 0", bus.bridge_rd_hit); end
        seen_done = 1'b0;
        repeat (3) begin
            tick();
            if (bus.req_done === 1'b1) seen_done = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            tick();
            if (bus.req_done === 1'b1) seen_done = 1'b1;
        end
        n_checks++; if (seen_done) begin n_fail++; $display("FAIL rst_no_done: got 1 want 0"); end
        rd_q.push_back({1'b1, 32'h0});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL rst_cmd_cleared: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
        start_cmd(16'h00C2, {4{32'hD}}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_next_ack: got 0 want 1 within 20 cycles"); end
        rd_q.push_back({1'b1, 32'h434D_00C2});
        bus_read(32'h0000_1000, d, h);
        e = rd_q.pop_front();
        n_checks++; if ({h, d} !== {e.hit, e.data}) begin n_fail++; $display("FAIL rst_next_read: got hit=%b data=%h want hit=%b data=%h", h, d, e.hit, e.data); end
        done_q.push_back({16'h00C2, 128'h0});
        bus_write(32'h0000_1000, 32'h4F4B_00C2);
        n_checks++;
        if (bus.req_done !== 1'b1) begin
            n_fail++; $display("FAIL rst_next_done: got %b want 1", bus.req_done);
        end else begin
            de = done_q.pop_front();
            n_checks++; if ({bus.req_result, bus.req_response} !== {de.result, de.resp}) begin n_fail++; $display("FAIL rst_next_result: got %h/%h want %h/%h", bus.req_result, bus.req_response, de.result, de.resp); end
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_decode();
        test_command();
        test_progress();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        n_checks++; if (done_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending completions want 0", done_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
